// File: rtl/fp_div_lane_arbiter.sv
// rtl/fp_div_lane_arbiter.sv - four-lane round-robin front end for one shared fixed-latency FP divider
// Optional per-lane issue and stall counters: define FP_DIV_ARB_STATS_EN.
module fp_div_lane_arbiter #(
   parameter int BW    = 32,
   parameter int BWB   = BW/8,
   parameter int LAT   = 28,
   parameter int DEPTH = 4
) (
   input  logic               clk_line,
   input  logic               clk_line_rst_high,
   input  logic [3:0]         stream_in_TVALID,
   input  logic [4*BW-1:0]    stream_in_TDATA,
   input  logic [4*BWB-1:0]   stream_in_TKEEP,
   input  logic [3:0]         stream_in_TLAST,
   output logic [3:0]         stream_in_TREADY,
   input  logic [3:0]         stream_out_TREADY,
   output logic [3:0]         stream_out_TVALID,
   output logic [4*BW-1:0]    stream_out_TDATA,
   output logic [4*BWB-1:0]   stream_out_TKEEP,
   output logic [3:0]         stream_out_TLAST,
   output logic               div_in_valid,
   output logic [BW-1:0]      div_in_a,
   output logic [BW-1:0]      div_in_b,
   input  logic               div_res_valid,
   input  logic [BW-1:0]      div_res_data,
   output logic               err,
   output logic [4*32-1:0]    stat_issued,
   output logic [31:0]        stat_stall
);

   localparam logic [1:0] ST_EMPTY  = 2'd0;
   localparam logic [1:0] ST_HAVE_A = 2'd1;
   localparam logic [1:0] ST_PAIR   = 2'd2;

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int DW = $clog2(LAT + 1);

   localparam logic [CW-1:0] CR_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CR_ONE  = CW'(1);
   localparam logic [PW:0]   PTR_ONE = (PW+1)'(1);
   localparam logic [DW-1:0] DR_INIT = DW'(LAT);
   localparam logic [DW-1:0] DR_ONE  = DW'(1);

   logic [1:0]       state_q [4], state_d [4];
   logic [BW-1:0]    a_q [4], a_d [4];
   logic [BW-1:0]    b_q [4], b_d [4];
   logic [3:0]       last_q, last_d;
   logic [CW-1:0]    credit_q [4], credit_d [4];
   logic [1:0]       rr_q, rr_d;
   logic [3:0]       tag_q [LAT], tag_d [LAT];
   logic [BW-1:0]    mem_q [4][DEPTH], mem_d [4][DEPTH];
   logic [DEPTH-1:0] fl_q [4], fl_d [4];
   logic [PW:0]      wr_q [4], wr_d [4];
   logic [PW:0]      rd_q [4], rd_d [4];
   logic [DW-1:0]    drain_q, drain_d;
   logic             err_q, err_d;

   logic [3:0]       in_beat, elig, grant_oh, push, pop;
   logic             grant_valid;
   logic [1:0]       grant_lane;
   logic             a_last_err;
   logic [3:0]       tag_out;
   logic             res_ok, tag_mismatch;
   logic             unused_tkeep;

   assign unused_tkeep = ^stream_in_TKEEP;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         stream_in_TREADY[i] = (state_q[i] != ST_PAIR);
         elig[i]             = (state_q[i] == ST_PAIR) && (credit_q[i] != '0);
      end
   end

   assign in_beat = stream_in_TVALID & stream_in_TREADY;

   // Search starts at rr_q and wraps; first eligible lane wins.
   always_comb begin
      logic [1:0] idx;
      idx         = 2'd0;
      grant_valid = 1'b0;
      grant_lane  = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_q + 2'(k);
         if (!grant_valid && elig[idx]) begin
            grant_valid = 1'b1;
            grant_lane  = idx;
         end
      end
      grant_oh = '0;
      if (grant_valid) grant_oh[grant_lane] = 1'b1;
      rr_d = grant_valid ? grant_lane + 2'd1 : rr_q;
   end

   assign div_in_valid = grant_valid;
   assign div_in_a     = grant_valid ? a_q[grant_lane] : '0;
   assign div_in_b     = grant_valid ? b_q[grant_lane] : '0;

   always_comb begin
      a_last_err = 1'b0;
      last_d     = last_q;
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         a_d[i]     = a_q[i];
         b_d[i]     = b_q[i];
         case (state_q[i])
            ST_EMPTY: if (in_beat[i]) begin
               a_d[i]     = stream_in_TDATA[i*BW +: BW];
               state_d[i] = ST_HAVE_A;
               if (stream_in_TLAST[i]) a_last_err = 1'b1;
            end
            ST_HAVE_A: if (in_beat[i]) begin
               b_d[i]     = stream_in_TDATA[i*BW +: BW];
               last_d[i]  = stream_in_TLAST[i];
               state_d[i] = ST_PAIR;
            end
            ST_PAIR: if (grant_oh[i]) state_d[i] = ST_EMPTY;
            default: state_d[i] = ST_EMPTY;
         endcase
      end
   end

   // Tag word: {valid, lane[1:0], last}, aligned with the divider pipeline.
   always_comb begin
      for (int k = 0; k < LAT; k++) tag_d[k] = '0;
      tag_d[0] = grant_valid ? {1'b1, grant_lane, last_q[grant_lane]} : 4'd0;
      for (int k = 1; k < LAT; k++) tag_d[k] = tag_q[k-1];
   end

   assign tag_out      = tag_q[LAT-1];
   assign res_ok       = div_res_valid && tag_out[3];
   assign tag_mismatch = div_res_valid != tag_out[3];

   always_comb begin
      drain_d = (drain_q != '0) ? drain_q - DR_ONE : drain_q;
      err_d   = err_q | a_last_err | (tag_mismatch && (drain_q == '0));
   end

   always_comb begin
      stream_out_TVALID = '0;
      stream_out_TDATA  = '0;
      stream_out_TKEEP  = '0;
      stream_out_TLAST  = '0;
      for (int i = 0; i < 4; i++) begin
         stream_out_TVALID[i] = (wr_q[i] != rd_q[i]);
         if (stream_out_TVALID[i]) begin
            stream_out_TDATA[i*BW +: BW]   = mem_q[i][rd_q[i][PW-1:0]];
            stream_out_TKEEP[i*BWB +: BWB] = '1;
            stream_out_TLAST[i]            = fl_q[i][rd_q[i][PW-1:0]];
         end
      end
   end

   assign pop = stream_out_TVALID & stream_out_TREADY;

   // Credits reserve a FIFO slot at grant time, so a push never finds the FIFO full.
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < 4; i++) begin
         push[i]     = res_ok && (tag_out[2:1] == 2'(i));
         fl_d[i]     = fl_q[i];
         wr_d[i]     = wr_q[i];
         rd_d[i]     = rd_q[i];
         credit_d[i] = credit_q[i];
         if (push[i]) begin
            mem_d[i][wr_q[i][PW-1:0]] = div_res_data;
            fl_d[i][wr_q[i][PW-1:0]]  = tag_out[0];
            wr_d[i]                   = wr_q[i] + PTR_ONE;
         end
         if (pop[i]) rd_d[i] = rd_q[i] + PTR_ONE;
         if (grant_oh[i] && !pop[i])      credit_d[i] = credit_q[i] - CR_ONE;
         else if (!grant_oh[i] && pop[i]) credit_d[i] = credit_q[i] + CR_ONE;
      end
   end

   always_ff @(posedge clk_line) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk_line) begin
      if (clk_line_rst_high) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i]  <= ST_EMPTY;
            a_q[i]      <= '0;
            b_q[i]      <= '0;
            credit_q[i] <= CR_FULL;
            fl_q[i]     <= '0;
            wr_q[i]     <= '0;
            rd_q[i]     <= '0;
         end
         for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
         last_q  <= '0;
         rr_q    <= '0;
         drain_q <= DR_INIT;
         err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i]  <= state_d[i];
            a_q[i]      <= a_d[i];
            b_q[i]      <= b_d[i];
            credit_q[i] <= credit_d[i];
            fl_q[i]     <= fl_d[i];
            wr_q[i]     <= wr_d[i];
            rd_q[i]     <= rd_d[i];
         end
         for (int k = 0; k < LAT; k++) tag_q[k] <= tag_d[k];
         last_q  <= last_d;
         rr_q    <= rr_d;
         drain_q <= drain_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q;

`ifdef FP_DIV_ARB_STATS_EN
   logic [31:0] issued_q [4], issued_d [4];
   logic [31:0] stall_q, stall_d;

   always_comb begin
      for (int i = 0; i < 4; i++)
         issued_d[i] = grant_oh[i] ? issued_q[i] + 32'd1 : issued_q[i];
      stall_d = (!grant_valid && (stream_in_TREADY != 4'hF)) ? stall_q + 32'd1 : stall_q;
   end

   always_ff @(posedge clk_line) begin
      if (clk_line_rst_high) begin
         for (int i = 0; i < 4; i++) issued_q[i] <= '0;
         stall_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) issued_q[i] <= issued_d[i];
         stall_q <= stall_d;
      end
   end

   assign stat_issued = {issued_q[3], issued_q[2], issued_q[1], issued_q[0]};
   assign stat_stall  = stall_q;
`else
   assign stat_issued = '0;
   assign stat_stall  = '0;
`endif

endmodule
